proc_cmd_sequencer: RTL

// Front-panel command controller for the Processor.
// - Debounces the 3-bit button bus and decodes press events into commands.
// - Writes the initial byte position into processor data memory via a req/ack handshake.
// - Latches the algorithm select.
// - Holds the core in reset until a valid START, and releases/re-asserts it on START/STOP.

---
 rtl/proc_cmd_sequencer_if.sv | 38 +++
 rtl/proc_cmd_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/proc_cmd_sequencer_if.sv
// -----------------------------------------------------------------------------
// proc_cmd_sequencer_if
// Groups the front-panel inputs, the data-memory write port and the core
// control outputs of the command sequencer.
//   btn        raw 3-bit button bus (asynchronous, bouncy)
//   bytePos    switch value: initial position or algorithm select
//   mem_we     memory write request, held until mem_ack or timeout
//   mem_addr   memory write address
//   mem_wdata  memory write data, {24'b0, latched bytePos}
//   mem_ack    memory accepted the write this cycle
//   alg_sel    selected algorithm
//   cpu_rst    reset to the processor core, 1 = held
//   busy       high while a position write is in flight
//   err        one-cycle pulse on rejected command or write timeout
// Modports: master = the sequencer, slave = the environment driving it.
// -----------------------------------------------------------------------------
interface proc_cmd_sequencer_if;
    logic [2:0]  btn;
    logic [7:0]  bytePos;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [1:0]  alg_sel;
    logic        cpu_rst;
    logic        busy;
    logic        err;

    modport master (
        input  btn, bytePos, mem_ack,
        output mem_we, mem_addr, mem_wdata, alg_sel, cpu_rst, busy, err
    );

    modport slave (
        output btn, bytePos, mem_ack,
        input  mem_we, mem_addr, mem_wdata, alg_sel, cpu_rst, busy, err
    );
endinterface

// File: rtl/proc_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// proc_cmd_sequencer
// Front-panel command controller for the processor. Synchronizes and
// debounces the button bus, turns each fresh press into a command, writes the
// initial byte position into data memory over a req/ack handshake, latches
// the algorithm select and holds the core in reset until a valid START.
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous reset, active-high
//   bus   proc_cmd_sequencer_if.master (buttons, switches, memory write port,
//         alg_sel, cpu_rst, busy, err)
// -----------------------------------------------------------------------------
module proc_cmd_sequencer #(
    parameter int         DB_CYCLES  = 500000,
    parameter logic [7:0] POS_ADDR   = 8'd0,
    parameter int         WR_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    proc_cmd_sequencer_if.master   bus
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam int TW = $clog2(WR_TIMEOUT + 1);
    localparam logic [CW-1:0] DB_MAX  = CW'(DB_CYCLES);
    localparam logic [TW-1:0] WR_LAST = TW'(WR_TIMEOUT - 1);

    localparam logic [2:0] CMD_LOAD_POS = 3'b011;
    localparam logic [2:0] CMD_SEL_ALG  = 3'b110;
    localparam logic [2:0] CMD_START    = 3'b100;
    localparam logic [2:0] CMD_STOP     = 3'b001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t        state;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    cand;        // synced value currently being qualified
    logic [CW-1:0] cnt;         // consecutive samples equal to cand (saturates)
    logic [2:0]    db;          // debounced button value
    logic          cmd_valid;   // one-cycle pulse: db went 000 -> nonzero
    logic [2:0]    cmd;
    logic          pos_loaded;
    logic [TW-1:0] wr_cnt;      // cycles spent waiting for mem_ack

    // Button synchronizer, debounce counter and press-event detection.
    // cnt reaching DB_MAX means the last DB_CYCLES synced samples all equalled
    // cand, so cand becomes the debounced value on this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= 3'b000;
            sync2     <= 3'b000;
            cand      <= 3'b000;
            cnt       <= '0;
            db        <= 3'b000;
            cmd_valid <= 1'b0;
            cmd       <= 3'b000;
        end else begin
            sync1     <= bus.btn;
            sync2     <= sync1;
            cmd_valid <= 1'b0;
            if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= CW'(1);
            end else if (cnt != DB_MAX) begin
                cnt <= cnt + CW'(1);
            end else begin
                cnt <= cnt;
            end
            if (cnt == DB_MAX) begin
                db        <= cand;
                cmd_valid <= (db == 3'b000) && (cand != 3'b000);
                cmd       <= cand;
            end else begin
                db <= db;
            end
        end
    end

    // Command FSM with registered outputs; err defaults low every cycle so
    // it can only pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= 8'd0;
            bus.mem_wdata <= 32'd0;
            bus.alg_sel   <= 2'd0;
            bus.cpu_rst   <= 1'b1;
            bus.busy      <= 1'b0;
            bus.err       <= 1'b0;
            pos_loaded    <= 1'b0;
            wr_cnt        <= '0;
        end else begin
            bus.err <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        case (cmd)
                            CMD_LOAD_POS: begin
                                bus.mem_wdata <= {24'd0, bus.bytePos};
                                bus.mem_addr  <= POS_ADDR;
                                bus.mem_we    <= 1'b1;
                                bus.busy      <= 1'b1;
                                wr_cnt        <= '0;
                                state         <= WRITE;
                            end
                            CMD_SEL_ALG: begin
                                bus.alg_sel <= bus.bytePos[1:0];
                            end
                            CMD_START: begin
                                if (pos_loaded) begin
                                    bus.cpu_rst <= 1'b0;
                                    state       <= RUN;
                                end else begin
                                    bus.err <= 1'b1;
                                end
                            end
                            CMD_STOP: begin
                                state <= IDLE;
                            end
                            default: begin
                                bus.err <= 1'b1;
                            end
                        endcase
                    end else begin
                        state <= IDLE;
                    end
                end
                WRITE: begin
                    // A press during the write is rejected; the write goes on.
                    if (cmd_valid) begin
                        bus.err <= 1'b1;
                    end else begin
                        bus.err <= 1'b0;
                    end
                    if (bus.mem_ack) begin
                        bus.mem_we <= 1'b0;
                        bus.busy   <= 1'b0;
                        pos_loaded <= 1'b1;
                        state      <= IDLE;
                    end else if (wr_cnt == WR_LAST) begin
                        bus.mem_we <= 1'b0;
                        bus.busy   <= 1'b0;
                        bus.err    <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        wr_cnt <= wr_cnt + TW'(1);
                    end
                end
                RUN: begin
                    if (cmd_valid) begin
                        if (cmd == CMD_STOP) begin
                            bus.cpu_rst <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            bus.err <= 1'b1;
                        end
                    end else begin
                        state <= RUN;
                    end
                end
                default: begin
                    bus.mem_we  <= 1'b0;
                    bus.busy    <= 1'b0;
                    bus.cpu_rst <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
